nthband_scheduler: RTL
======================

# nthband_scheduler

Sequences the per-block band traversal around `nthband_predictor`. It routes the reconstructed-sample stream (`xhat`) of band 0 to the first-band path, and the samples of bands 1..NUM_BANDS-1 to the nth-band predictor. For each nth band it collects one `alpha`, `xmean` and `xhatmean` and issues each exactly once to the predictor. It also generates the per-band `xhat_last_s` flag from an internal sample counter. It sits between the block-level sample source, the alpha/mean calculators and the predictor pair.

## Interface
Parameters:
- DATA_WIDTH, 16, sample and mean width
- ALPHA_WIDTH, 10, alpha coefficient width
- BLOCK_SIZE_LOG, 8, log2 of samples per band in a block
- NUM_BANDS, 224, bands per block (must be ≥2)

Ports (every stream is AXI-Stream valid/ready/data):
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset (the only reset)
- xhat_valid/ready/data  in/out/in  1/1/DATA_WIDTH  sample stream of the block, band-major
- alpha_valid/ready/data  in/out/in  1/1/ALPHA_WIDTH  one beat per nth band
- xmean_valid/ready/data  in/out/in  1/1/DATA_WIDTH  one beat per nth band
- xhatmean_valid/ready/data  in/out/in  1/1/DATA_WIDTH  one beat per nth band
- fb_xhat_valid/ready/data/last_s  out/in/out/out  1/1/DATA_WIDTH/1  band-0 samples to the first-band path
- nb_xhat_valid/ready/data/last_s  out/in/out/out  1/1/DATA_WIDTH/1  nth-band samples to the predictor
- nb_alpha_valid/ready/data  out/in/out  1/1/ALPHA_WIDTH  issued alpha
- nb_xmean_valid/ready/data  out/in/out  1/1/DATA_WIDTH  issued xmean
- nb_xhatmean_valid/ready/data  out/in/out  1/1/DATA_WIDTH  issued xhatmean
- band_index  out  8  current band (0..NUM_BANDS-1)
- block_done  out  1  one-cycle pulse after the last sample of the last band is accepted

## Operation
States: FIRST, LOAD, STREAM, DRAIN.

- **FIRST**
  - `xhat` is combinationally forwarded to `fb_xhat`.
  - `fb_xhat_last_s` is 1 when sample_cnt = 2^BLOCK_SIZE_LOG−1.
  - On the last-sample handshake: sample_cnt←0, band_index←1, go to LOAD.
- **LOAD**
  - `xhat_ready`=0.
  - Three independent param slots. Each slot accepts its input (ready = !slot_full) and latches the data.
  - Go to STREAM in the cycle after all three slots are full.
- **STREAM**
  - `xhat` is combinationally forwarded to `nb_xhat`; last_s is generated as in FIRST.
  - Each full slot drives its `nb_*_valid` until accepted, then clears. No slot is ever reissued within a band.
  - On the last-sample handshake:
    - If all slots are empty (including those accepted in that same cycle), advance the band.
    - Otherwise go to DRAIN, with `xhat_ready`=0.
- **DRAIN**
  - Waits until all slots are empty, then advances the band.
- **Band advance**
  - If band_index = NUM_BANDS−1: band_index←0, pulse `block_done`, go to FIRST.
  - Otherwise: band_index+1, go to LOAD.
- Param inputs have ready=0 outside LOAD.
- The unused routed output (fb or nb) has valid=0.
- Counters: sample_cnt is BLOCK_SIZE_LOG bits and wraps naturally. band_index saturates at NUM_BANDS−1 and wraps to 0.

## Timing
- **Reset values** (rst=0, applied immediately and asynchronously): state=FIRST, counters 0, slots empty, all valid/ready outputs 0, `block_done`=0, data outputs 0.
- **Sample path latency**: 0 cycles (combinational valid/data forward, ready back-propagated).
- **Param path latency**: input beat to `nb_*_valid` is 1 cycle minimum (LOAD→STREAM registered).
- **Band-to-band bubble**: minimum 1 cycle (LOAD with params already valid).
- **Handshake rules**
  - Once asserted, a valid is held with stable data until ready.
  - `last_s` is stable with its sample.
- **Mid-operation reset**: in-flight slots are discarded and traversal restarts at band 0.

## Structure
- Package `lcplc_sched_pkg`: state enum (FIRST, LOAD, STREAM, DRAIN) and helper function `clog2`.
- One sub-module `param_slot` (parameter WIDTH): single-entry valid/ready register with a full flag, instantiated three times.

## Test plan
- **Basic block**: BLOCK_SIZE_LOG=2, NUM_BANDS=3, samples 0..11, params ready immediately.
  - Expect fb_xhat to receive 0..3 with last_s on 3, and nb_xhat to receive 4..11 with last_s on 7 and 11.
  - Expect one beat each on nb_alpha/xmean/xhatmean per band (2 total), and `block_done` one cycle after sample 11.
- **Staggered params**: alpha arrives at cycle+0, xmean at +3, xhatmean at +7. Expect STREAM entry the cycle after +7 and `xhat_ready`=0 until then.
- **Slow predictor params**: nb_alpha_ready held low until after the last sample of band 1. Expect DRAIN with `xhat_ready`=0, then band 2 starts only after alpha is accepted.
- **Backpressure**: nb_xhat_ready toggling 1/0 randomly. Expect no sample lost or duplicated, last_s aligned with sample_cnt=3.
- **Reset mid-band**: rst=0 during band 1, sample 2. Expect all outputs 0 immediately; after release, samples route to fb_xhat starting at band_index=0.
- **Two back-to-back blocks**: expect `block_done` pulsed twice and band_index sequence 0,1,2,0,1,2.

Source files
------------

// File: rtl/lcplc_sched_pkg.sv
// Shared definitions for the nth-band scheduler.
//   sched_state_t : band traversal states
//   clog2         : ceiling log2 used to size the band counter (minimum 1)
package lcplc_sched_pkg;

    typedef enum logic [1:0] {
        FIRST  = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } sched_state_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return (result == 0) ? 1 : result;
    endfunction

endpackage

// File: rtl/param_slot.sv
// Single-entry parameter holding register with valid/ready on both sides.
//   clk, rst             : clock, asynchronous active-low reset
//   accept_en            : slot may take a new beat (scheduler is loading)
//   issue_en             : slot may present its beat downstream
//   in_valid/ready/data  : upstream parameter beat
//   out_valid/ready/data : downstream parameter beat
//   full_next            : slot occupancy after the current cycle's handshakes
module param_slot #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept_en,
    input  logic             issue_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             full_next
);

    logic             full_q;
    logic [WIDTH-1:0] data_q;
    logic             in_fire;
    logic             out_fire;

    assign in_ready  = accept_en & ~full_q;
    assign out_valid = issue_en & full_q;
    assign out_data  = data_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Lets the scheduler react in the same cycle a slot fills or drains.
    assign full_next = (full_q & ~out_fire) | in_fire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (in_fire) begin
            full_q <= 1'b1;
            data_q <= in_data;
        end else if (out_fire) begin
            full_q <= 1'b0;
        end
    end

endmodule

// File: rtl/nthband_scheduler.sv
// Band traversal sequencer in front of the first-band / nth-band predictors.
// Band 0 samples go to fb_xhat; bands 1..NUM_BANDS-1 go to nb_xhat, each band
// preceded by collecting one alpha, xmean and xhatmean which are issued once.
//   clk, rst                      : clock, asynchronous active-low reset
//   xhat_*                        : block sample stream, band-major
//   alpha_*, xmean_*, xhatmean_*  : one parameter beat per nth band
//   fb_xhat_*                     : band-0 samples with last_s flag
//   nb_xhat_*                     : nth-band samples with last_s flag
//   nb_alpha_*, nb_xmean_*, nb_xhatmean_* : parameters issued to the predictor
//   band_index                    : current band
//   block_done                    : pulse after the last sample of the block
module nthband_scheduler
    import lcplc_sched_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int ALPHA_WIDTH    = 10,
    parameter int BLOCK_SIZE_LOG = 8,
    parameter int NUM_BANDS      = 224
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   xhat_valid,
    output logic                   xhat_ready,
    input  logic [DATA_WIDTH-1:0]  xhat_data,
    input  logic                   alpha_valid,
    output logic                   alpha_ready,
    input  logic [ALPHA_WIDTH-1:0] alpha_data,
    input  logic                   xmean_valid,
    output logic                   xmean_ready,
    input  logic [DATA_WIDTH-1:0]  xmean_data,
    input  logic                   xhatmean_valid,
    output logic                   xhatmean_ready,
    input  logic [DATA_WIDTH-1:0]  xhatmean_data,
    output logic                   fb_xhat_valid,
    input  logic                   fb_xhat_ready,
    output logic [DATA_WIDTH-1:0]  fb_xhat_data,
    output logic                   fb_xhat_last_s,
    output logic                   nb_xhat_valid,
    input  logic                   nb_xhat_ready,
    output logic [DATA_WIDTH-1:0]  nb_xhat_data,
    output logic                   nb_xhat_last_s,
    output logic                   nb_alpha_valid,
    input  logic                   nb_alpha_ready,
    output logic [ALPHA_WIDTH-1:0] nb_alpha_data,
    output logic                   nb_xmean_valid,
    input  logic                   nb_xmean_ready,
    output logic [DATA_WIDTH-1:0]  nb_xmean_data,
    output logic                   nb_xhatmean_valid,
    input  logic                   nb_xhatmean_ready,
    output logic [DATA_WIDTH-1:0]  nb_xhatmean_data,
    output logic [7:0]             band_index,
    output logic                   block_done
);

    localparam int BAND_W = clog2(NUM_BANDS);
    localparam logic [BAND_W-1:0]         LAST_BAND = BAND_W'(NUM_BANDS - 1);
    localparam logic [BAND_W-1:0]         BAND_ONE  = BAND_W'(1);
    localparam logic [BLOCK_SIZE_LOG-1:0] CNT_ONE   = BLOCK_SIZE_LOG'(1);

    sched_state_t              state_q, state_d;
    logic [BLOCK_SIZE_LOG-1:0] cnt_q, cnt_d;
    logic [BAND_W-1:0]         band_q, band_d;
    logic                      done_q, done_d;
    logic                      active_q;
    logic                      advance;

    logic                      route_fb;
    logic                      route_nb;
    logic                      sample_last;
    logic                      xhat_fire;
    logic                      accept_en;
    logic                      issue_en;
    logic [2:0]                full_next;
    logic                      all_full_next;
    logic                      all_empty_next;

    // active_q holds the sample path closed while reset is asserted, so the
    // combinational forward cannot leak valid/ready/data during reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q <= 1'b0;
        end else begin
            active_q <= 1'b1;
        end
    end

    assign route_fb    = active_q && (state_q == FIRST);
    assign route_nb    = active_q && (state_q == STREAM);
    assign sample_last = &cnt_q;
    assign accept_en   = (state_q == LOAD);
    assign issue_en    = (state_q == STREAM) || (state_q == DRAIN);

    always_comb begin
        xhat_ready     = 1'b0;
        fb_xhat_valid  = 1'b0;
        fb_xhat_data   = '0;
        fb_xhat_last_s = 1'b0;
        nb_xhat_valid  = 1'b0;
        nb_xhat_data   = '0;
        nb_xhat_last_s = 1'b0;
        if (route_fb) begin
            xhat_ready     = fb_xhat_ready;
            fb_xhat_valid  = xhat_valid;
            fb_xhat_data   = xhat_valid ? xhat_data : '0;
            fb_xhat_last_s = xhat_valid & sample_last;
        end else if (route_nb) begin
            xhat_ready     = nb_xhat_ready;
            nb_xhat_valid  = xhat_valid;
            nb_xhat_data   = xhat_valid ? xhat_data : '0;
            nb_xhat_last_s = xhat_valid & sample_last;
        end
    end

    assign xhat_fire = xhat_valid & xhat_ready;

    param_slot #(.WIDTH(ALPHA_WIDTH)) u_alpha_slot (
        .clk       (clk),
        .rst       (rst),
        .accept_en (accept_en),
        .issue_en  (issue_en),
        .in_valid  (alpha_valid),
        .in_ready  (alpha_ready),
        .in_data   (alpha_data),
        .out_valid (nb_alpha_valid),
        .out_ready (nb_alpha_ready),
        .out_data  (nb_alpha_data),
        .full_next (full_next[0])
    );

    param_slot #(.WIDTH(DATA_WIDTH)) u_xmean_slot (
        .clk       (clk),
        .rst       (rst),
        .accept_en (accept_en),
        .issue_en  (issue_en),
        .in_valid  (xmean_valid),
        .in_ready  (xmean_ready),
        .in_data   (xmean_data),
        .out_valid (nb_xmean_valid),
        .out_ready (nb_xmean_ready),
        .out_data  (nb_xmean_data),
        .full_next (full_next[1])
    );

    param_slot #(.WIDTH(DATA_WIDTH)) u_xhatmean_slot (
        .clk       (clk),
        .rst       (rst),
        .accept_en (accept_en),
        .issue_en  (issue_en),
        .in_valid  (xhatmean_valid),
        .in_ready  (xhatmean_ready),
        .in_data   (xhatmean_data),
        .out_valid (nb_xhatmean_valid),
        .out_ready (nb_xhatmean_ready),
        .out_data  (nb_xhatmean_data),
        .full_next (full_next[2])
    );

    // Looking at post-handshake occupancy lets LOAD leave in the cycle the
    // last parameter lands, and lets STREAM skip DRAIN when the final
    // parameter is accepted together with the final sample.
    assign all_full_next  = &full_next;
    assign all_empty_next = ~|full_next;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        band_d  = band_q;
        done_d  = 1'b0;
        advance = 1'b0;
        case (state_q)
            FIRST: begin
                if (xhat_fire) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (sample_last) begin
                        band_d  = BAND_ONE;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (all_full_next) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (xhat_fire) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (sample_last) begin
                        if (all_empty_next) begin
                            advance = 1'b1;
                        end else begin
                            state_d = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                if (all_empty_next) begin
                    advance = 1'b1;
                end
            end
            default: begin
                state_d = FIRST;
            end
        endcase

        if (advance) begin
            if (band_q == LAST_BAND) begin
                band_d  = '0;
                done_d  = 1'b1;
                state_d = FIRST;
            end else begin
                band_d  = band_q + BAND_ONE;
                state_d = LOAD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FIRST;
            cnt_q   <= '0;
            band_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            band_q  <= band_d;
            done_q  <= done_d;
        end
    end

    assign band_index = 8'(band_q);
    assign block_done = done_q;

endmodule
